serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder. Takes two WIDTH-bit operands and a carry-in through a start pulse.
- Feeds one bit pair per clock, LSB first, through a single full_adder cell, with the carry held in a flip-flop.
- Returns a WIDTH-bit sum and a carry-out, with a one-cycle done strobe.
- Sits directly upstream of the full_adder cell. It is the sequencing and operand-feeding stage that drives that cell, trading latency for area.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on the clk rising edge.
- a_in  input  WIDTH  operand A; captured when start is accepted.
- b_in  input  WIDTH  operand B; captured when start is accepted.
- cin_in  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle strobe: sum_out/cout hold a new result.
- sum_out  output  WIDTH  result sum; registered; stable between completions.
- cout  output  1  result carry-out; registered; stable between completions.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, sum_out=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter are cleared.
  - Reset asserted mid-addition aborts the addition; no done is produced.
- State machine: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. If start=1 on an edge, load a_sr<=a_in, b_sr<=b_in, c<=cin_in, cnt<=0, then go to RUN.
  - RUN: busy=1, done=0. Each edge:
    - The full_adder inputs are a_sr[0], b_sr[0], c.
    - c <= carry.
    - a_sr and b_sr shift right by 1, with zero fill.
    - The sum bit shifts into s_sr from the MSB end (s_sr <= {sum, s_sr[WIDTH-1:1]}).
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1, load sum_out <= {sum, s_sr[WIDTH-1:1]} and cout <= carry, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. On the next edge:
    - If start=1, load new operands as in IDLE and go to RUN (back-to-back is allowed).
    - Otherwise go to IDLE.
- start while in RUN is ignored. Operands are not re-captured, and the in-flight addition is unaffected.
- a_in, b_in and cin_in are don't-care except on an accepting edge.
- Latency: start is accepted on edge E0. The result is registered on edge E(WIDTH). done is high during the cycle that follows E(WIDTH).
- Throughput: one addition per WIDTH+1 cycles when back-to-back.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin_in, computed modulo 2^(WIDTH+1). There is no signed interpretation; overflow detection is the consumer's job.
- Counter width is clog2(WIDTH). cnt never exceeds WIDTH-1.
- sum_out and cout change only on the RUN->DONE edge and on reset. They hold their last value through IDLE and through the next RUN.
- Outputs busy and done are decoded from the state register; they are glitch-free registered-state decodes.

Decomposition:
- Shared package/header holds the state encoding localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2. 2'd3 is illegal and recovers to S_IDLE.
- Sub-module: one instance of the existing full_adder cell (ports a, b, cin, sum, carry) for the per-bit arithmetic. No other sub-modules.
- Shift registers, counter and FSM live in serial_adder.

Test Plan:
- WIDTH=8, start with a_in=8'h5A, b_in=8'h33, cin_in=0 -> busy high 8 cycles; done pulses exactly once, 8 edges after the accepting edge; sum_out=8'h8D, cout=0.
- a_in=8'hFF, b_in=8'h01, cin_in=0 -> sum_out=8'h00, cout=1. a_in=8'hFF, b_in=8'hFF, cin_in=1 -> sum_out=8'hFF, cout=1. a=b=0, cin=0 -> sum_out=0, cout=0.
- Start 8'h10+8'h20. Pulse start again with 8'hAA+8'h55 in RUN cycle 3, and change a_in/b_in during RUN -> result 8'h30, cout=0; second request ignored; exactly one done.
- Start 8'h0F+8'h01. Assert rst after 4 RUN edges -> busy, done, sum_out and cout go to 0 immediately (asynchronously). After rst release, no done appears. A fresh 8'h03+8'h04 gives 8'h07.
- Back-to-back: hold start=1 continuously with 8'h80+8'h80, then 8'h01+8'h02 presented in the DONE cycle -> first done gives sum_out=8'h00, cout=1. Second done follows 9 edges later with sum_out=8'h03, cout=0. sum_out stays 8'h00 throughout the second RUN.
- Random regression, 1000 iterations, WIDTH=8 and WIDTH=13 -> {cout,sum_out} matches the reference a+b+cin every time; done count equals accepted-start count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// a helper that sizes the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of a counter that must reach width-1 without wrapping early.
  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the serial adder for per-bit arithmetic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through a single
// full_adder cell, LSB first, with the running carry held in a flip-flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-2:0] sSr_q, sSr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             faSum;
  logic             faCarry;
  logic [WIDTH-1:0] sumNext;

  full_adder uFullAdder (
    .a    (aSr_q[0]),
    .b    (bSr_q[0]),
    .cin  (carry_q),
    .sum  (faSum),
    .carry(faCarry)
  );

  // The oldest sum bit is never needed again, so the partial-sum register is
  // one bit narrower than the result and the final bit goes straight to sum_q.
  assign sumNext = {faSum, sSr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      sSr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      sSr_q   <= sSr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    aSr_d   = aSr_q;
    bSr_d   = bSr_q;
    sSr_d   = sSr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          aSr_d   = a_in;
          bSr_d   = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        aSr_d   = {1'b0, aSr_q[WIDTH-1:1]};
        bSr_d   = {1'b0, bSr_q[WIDTH-1:1]};
        sSr_d   = sumNext[WIDTH-1:1];
        carry_d = faCarry;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the result and park the counter at zero.
        if (cnt_q == LAST_BIT) begin
          sum_d   = sumNext;
          cout_d  = faCarry;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases plus random regression on
// an 8-bit and a 13-bit instance, checked against plain a+b+cin arithmetic.
module tb_serial_adder;

  logic        clk;
  logic        rst;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;

  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int total = 0;
  int bad = 0;
  int acc8 = 0;
  int doneCnt8 = 0;
  int acc13 = 0;
  int doneCnt13 = 0;

  logic [8:0]  expQ8[$];
  logic [13:0] expQ13[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a_in(a13), .b_in(b13), .cin_in(cin13),
    .busy(busy13), .done(done13), .sum_out(sum13), .cout(cout13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitors pop the expected result whenever a DUT strobes done.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      doneCnt8++;
      total++;
      if (expQ8.size() == 0) begin
        bad++;
        $display("[TB] FAIL done8_unexpected: got %0h expected no done", {cout8, sum8});
      end else begin
        logic [8:0] e;
        e = expQ8.pop_front();
        if ({cout8, sum8} !== e) begin
          bad++;
          $display("[TB] FAIL result8: got %0h expected %0h", {cout8, sum8}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done13 === 1'b1) begin
      doneCnt13++;
      total++;
      if (expQ13.size() == 0) begin
        bad++;
        $display("[TB] FAIL done13_unexpected: got %0h expected no done", {cout13, sum13});
      end else begin
        logic [13:0] e;
        e = expQ13.pop_front();
        if ({cout13, sum13} !== e) begin
          bad++;
          $display("[TB] FAIL result13: got %0h expected %0h", {cout13, sum13}, e);
        end
      end
    end
  end

  // Presents a request; DUT must be in IDLE or DONE so the next edge accepts it.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #2;
    expQ8.push_back(9'(a) + 9'(b) + 9'(c));
    acc8++;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic applyStimulus13(input logic [12:0] a, input logic [12:0] b, input logic c);
    start13 = 1'b1; a13 = a; b13 = b; cin13 = c;
    @(posedge clk); #2;
    expQ13.push_back(14'(a) + 14'(b) + 14'(c));
    acc13++;
    start13 = 1'b0; a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
  endtask

  task automatic waitDone8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) return;
    end
    checkOutput("done8_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone13();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done13) return;
    end
    checkOutput("done13_timeout", 32'd0, 32'd1);
  endtask

  task automatic randomRun8();
    for (int n = 0; n < 1000; n++) begin
      applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom));
      waitDone8();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
  endtask

  task automatic randomRun13();
    for (int n = 0; n < 1000; n++) begin
      applyStimulus13(13'($urandom), 13'($urandom), 1'($urandom));
      waitDone13();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
  endtask

  initial begin
    logic [7:0] edgeA[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] edgeB[3] = '{8'h01, 8'hFF, 8'h00};
    logic       edgeC[3] = '{1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start13 = 0; a13 = 0; b13 = 0; cin13 = 0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_busy8", busy8, 0);
    checkOutput("reset_done8", done8, 0);
    checkOutput("reset_sum8", sum8, 0);
    checkOutput("reset_cout8", cout8, 0);
    checkOutput("reset_busy13", busy13, 0);
    checkOutput("reset_sum13", sum13, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    $display("[TB] basic latency 5A+33");
    applyStimulus8(8'h5A, 8'h33, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_busy_%0d", k), busy8, (k < 8) ? 1 : 0);
      checkOutput($sformatf("latency_done_%0d", k), done8, (k == 8) ? 1 : 0);
    end
    @(posedge clk); #2;

    $display("[TB] boundary operands");
    for (int i = 0; i < 3; i++) begin
      applyStimulus8(edgeA[i], edgeB[i], edgeC[i]);
      waitDone8();
      @(posedge clk); #2;
    end

    $display("[TB] start during RUN ignored");
    applyStimulus8(8'h10, 8'h20, 1'b0);
    repeat (2) begin @(posedge clk); #2; end
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk); #2;
    start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
    waitDone8();
    repeat (3) begin
      @(negedge clk);
      checkOutput("ignored_start_busy", busy8, 0);
      checkOutput("ignored_start_done", done8, 0);
    end
    @(posedge clk); #2;

    $display("[TB] reset mid-addition");
    applyStimulus8(8'h0F, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_done", done8, 0);
    checkOutput("abort_sum", sum8, 0);
    checkOutput("abort_cout", cout8, 0);
    expQ8.delete();
    acc8--;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      checkOutput("abort_no_done", done8, 0);
    end
    @(posedge clk); #2;
    applyStimulus8(8'h03, 8'h04, 1'b0);
    waitDone8();
    @(posedge clk); #2;

    $display("[TB] back-to-back");
    applyStimulus8(8'h80, 8'h80, 1'b0);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    waitDone8();
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    @(posedge clk); #2;
    expQ8.push_back(9'h003);
    acc8++;
    start8 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k < 9) begin
        checkOutput("b2b_hold_sum", sum8, 8'h00);
        checkOutput("b2b_hold_cout", cout8, 1);
        checkOutput("b2b_busy", busy8, 1);
      end else begin
        checkOutput("b2b_done_spacing", done8, 1);
      end
    end
    @(posedge clk); #2;

    $display("[TB] random regression");
    fork
      randomRun8();
      randomRun13();
    join
    repeat (5) @(negedge clk);

    checkOutput("done_count8", doneCnt8, acc8);
    checkOutput("done_count13", doneCnt13, acc13);
    checkOutput("pending8", expQ8.size(), 0);
    checkOutput("pending13", expQ13.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
